// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction, waits for the data-SRAM load
// response, buffers it across write-back stalls and forms the write-back bus.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 73,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [4:0]                 ms_to_ds_dest,
  output logic                       ms_to_ds_load,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_W  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b101;
  localparam logic [2:0] LD_HU = 3'b110;

  logic                       ms_valid_reg;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_reg;
  logic                       rdata_buf_valid_reg;
  logic [31:0]                rdata_buf_reg;

  logic [2:0]  ld_type;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        is_load;
  logic        ms_ready_go;
  logic        ms_leave;
  logic [31:0] load_data;
  logic [7:0]  byte_lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] final_result;

  assign ld_type    = es_to_ms_bus_reg[72:70];
  assign gr_we      = es_to_ms_bus_reg[69];
  assign dest       = es_to_ms_bus_reg[68:64];
  assign alu_result = es_to_ms_bus_reg[63:32];
  assign pc         = es_to_ms_bus_reg[31:0];

  assign is_load = (ld_type == LD_B) || (ld_type == LD_H) || (ld_type == LD_W) ||
                   (ld_type == LD_BU) || (ld_type == LD_HU);

  assign ms_ready_go    = !is_load || data_sram_data_ok || rdata_buf_valid_reg;
  assign ms_allowin     = !ms_valid_reg || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_reg && ms_ready_go;
  assign ms_leave       = ms_valid_reg && ms_ready_go && ws_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_reg     <= 1'b0;
      es_to_ms_bus_reg <= '0;
    end else if (ms_allowin) begin
      ms_valid_reg <= es_to_ms_valid;
      if (es_to_ms_valid) begin
        es_to_ms_bus_reg <= es_to_ms_bus;
      end
    end
  end

  // A response arriving while the buffer is already full belongs to no
  // resident load, so only the first one is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_buf_valid_reg <= 1'b0;
      rdata_buf_reg       <= '0;
    end else if (ms_leave) begin
      rdata_buf_valid_reg <= 1'b0;
    end else if (ms_valid_reg && is_load && data_sram_data_ok && !rdata_buf_valid_reg) begin
      rdata_buf_valid_reg <= 1'b1;
      rdata_buf_reg       <= data_sram_rdata;
    end
  end

  assign load_data = rdata_buf_valid_reg ? rdata_buf_reg : data_sram_rdata;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lane[gi] = load_data[gi*8 +: 8];
    end
  endgenerate

  assign sel_byte = byte_lane[alu_result[1:0]];
  assign sel_half = alu_result[1] ? load_data[31:16] : load_data[15:0];

  always_comb begin
    final_result = alu_result;
    case (ld_type)
      LD_B:    final_result = {{24{sel_byte[7]}}, sel_byte};
      LD_BU:   final_result = {24'b0, sel_byte};
      LD_H:    final_result = {{16{sel_half[15]}}, sel_half};
      LD_HU:   final_result = {16'b0, sel_half};
      LD_W:    final_result = load_data;
      default: final_result = alu_result;
    endcase
  end

  assign ms_to_ws_bus  = {gr_we, dest, final_result, pc};
  assign ms_to_ds_dest = (ms_valid_reg && gr_we) ? dest : 5'd0;
  assign ms_to_ds_load = ms_valid_reg && is_load;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: non-loads, load extraction, stall buffering,
// back-to-back loads and reset during an outstanding load.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [72:0] es_to_ms_bus;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [4:0]  ms_to_ds_dest;
  logic        ms_to_ds_load;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int checks = 0;
  int errors = 0;

  mem_stage #(.ES_TO_MS_BUS_WD(73), .MS_TO_WS_BUS_WD(70)) dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_dest     (ms_to_ds_dest),
    .ms_to_ds_load     (ms_to_ds_load),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [72:0] mk(input logic [2:0] ld, input logic we, input logic [4:0] d,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {ld, we, d, alu, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Extraction vectors, each load's data_ok arrives in its first cycle in stage
  logic [2:0]  x_ld  [6] = '{3'b110, 3'b010, 3'b011, 3'b101, 3'b001, 3'b100};
  logic [31:0] x_alu [6] = '{32'h2002, 32'h2003, 32'h2001, 32'h2001, 32'h2000, 32'h2002};
  logic [31:0] x_rd  [6] = '{32'h9ABC_0000, 32'h9ABC_0000, 32'h9ABC_0000,
                             32'h80AB_CDEF, 32'h80AB_CDEF, 32'h9ABC_0000};
  logic [31:0] x_exp [6] = '{32'h0000_9ABC, 32'hFFFF_9ABC, 32'h9ABC_0000,
                             32'h0000_00CD, 32'hFFFF_FFEF, 32'h0000_2002};

  initial begin
    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    tick();
    tick();
    reset = 1'b0;

    mid();
    check("rst_allowin", 70'(ms_allowin), 70'(1));
    check("rst_ws_valid", 70'(ms_to_ws_valid), 70'(0));
    check("rst_ds_dest", 70'(ms_to_ds_dest), 70'(0));
    check("rst_ds_load", 70'(ms_to_ds_load), 70'(0));
    check("rst_bus", ms_to_ws_bus, 70'(0));

    // Non-load
    tick();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b000, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0010);
    tick();
    es_to_ms_valid = 1'b0;
    mid();
    check("alu_ws_valid", 70'(ms_to_ws_valid), 70'(1));
    check("alu_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0010});
    check("alu_ds_dest", 70'(ms_to_ds_dest), 70'(5));
    check("alu_ds_load", 70'(ms_to_ds_load), 70'(0));
    tick();
    mid();
    check("alu_gone", 70'(ms_to_ws_valid), 70'(0));

    // ld.b off=3, data_ok in second cycle
    tick();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b001, 1'b1, 5'd7, 32'h0000_1003, 32'h1C00_0020);
    tick();
    es_to_ms_valid = 1'b0;
    mid();
    check("ldb_wait_valid", 70'(ms_to_ws_valid), 70'(0));
    check("ldb_wait_allowin", 70'(ms_allowin), 70'(0));
    check("ldb_ds_load", 70'(ms_to_ds_load), 70'(1));
    check("ldb_ds_dest", 70'(ms_to_ds_dest), 70'(7));
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h80AB_CDEF;
    mid();
    check("ldb_valid", 70'(ms_to_ws_valid), 70'(1));
    check("ldb_bus", ms_to_ws_bus, {1'b1, 5'd7, 32'hFFFF_FF80, 32'h1C00_0020});
    check("ldb_allowin", 70'(ms_allowin), 70'(1));
    tick();
    data_sram_data_ok = 1'b0;
    mid();
    check("ldb_gone", 70'(ms_to_ws_valid), 70'(0));

    for (int i = 0; i < 6; i++) begin
      tick();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk(x_ld[i], 1'b1, 5'd9, x_alu[i], 32'h1C00_0100 + 32'(i));
      tick();
      es_to_ms_valid = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata = x_rd[i];
      mid();
      check($sformatf("ext%0d_valid", i), 70'(ms_to_ws_valid), 70'(1));
      check($sformatf("ext%0d_result", i), 70'(ms_to_ws_bus[63:32]), 70'(x_exp[i]));
      tick();
      data_sram_data_ok = 1'b0;
    end

    // ld.w with write-back stalled for 3 cycles after data_ok
    tick();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b011, 1'b1, 5'd3, 32'h0000_3000, 32'h1C00_0200);
    tick();
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      mid();
      check($sformatf("stall%0d_valid", c), 70'(ms_to_ws_valid), 70'(1));
      check($sformatf("stall%0d_result", c), 70'(ms_to_ws_bus[63:32]), 70'(32'hCAFE_F00D));
      check($sformatf("stall%0d_allowin", c), 70'(ms_allowin), 70'(0));
      tick();
      // a stray pulse while the buffer is full must be ignored
      data_sram_data_ok = (c == 0);
      data_sram_rdata = (c == 0) ? 32'h1111_1111 : 32'hDEAD_BEEF;
    end
    ws_allowin = 1'b1;
    mid();
    check("stall_rel_valid", 70'(ms_to_ws_valid), 70'(1));
    check("stall_rel_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hCAFE_F00D));
    check("stall_rel_allowin", 70'(ms_allowin), 70'(1));
    tick();
    mid();
    check("stall_gone", 70'(ms_to_ws_valid), 70'(0));

    // Back-to-back loads
    tick();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b011, 1'b1, 5'd4, 32'h0000_4000, 32'h1C00_0300);
    tick();
    es_to_ms_bus = mk(3'b011, 1'b1, 5'd6, 32'h0000_5000, 32'h1C00_0304);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hAAAA_0001;
    mid();
    check("b2b_a_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hAAAA_0001));
    check("b2b_a_allowin", 70'(ms_allowin), 70'(1));
    tick();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h5555_5555;
    mid();
    check("b2b_b_wait0", 70'(ms_to_ws_valid), 70'(0));
    check("b2b_b_pc", 70'(ms_to_ws_bus[31:0]), 70'(32'h1C00_0304));
    tick();
    mid();
    check("b2b_b_wait1", 70'(ms_to_ws_valid), 70'(0));
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hBBBB_0002;
    mid();
    check("b2b_b_valid", 70'(ms_to_ws_valid), 70'(1));
    check("b2b_b_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hBBBB_0002));
    tick();
    data_sram_data_ok = 1'b0;

    // Buffered load leaves while the next load is captured: buffer must clear
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b011, 1'b1, 5'd8, 32'h0000_6000, 32'h1C00_0400);
    tick();
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1234_0000;
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b011, 1'b1, 5'd10, 32'h0000_7000, 32'h1C00_0404);
    mid();
    check("buf_b2b_a_result", 70'(ms_to_ws_bus[63:32]), 70'(32'h1234_0000));
    check("buf_b2b_a_allowin", 70'(ms_allowin), 70'(1));
    tick();
    es_to_ms_valid = 1'b0;
    mid();
    check("buf_b2b_b_noStale", 70'(ms_to_ws_valid), 70'(0));
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h5678_0000;
    mid();
    check("buf_b2b_b_result", 70'(ms_to_ws_bus[63:32]), 70'(32'h5678_0000));
    tick();
    data_sram_data_ok = 1'b0;

    // Reset while a load waits
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b011, 1'b1, 5'd12, 32'h0000_8000, 32'h1C00_0500);
    tick();
    es_to_ms_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mid();
    check("rst_mid_valid", 70'(ms_to_ws_valid), 70'(0));
    check("rst_mid_allowin", 70'(ms_allowin), 70'(1));
    check("rst_mid_ds_load", 70'(ms_to_ds_load), 70'(0));
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h7777_7777;
    mid();
    check("rst_late_ok_valid", 70'(ms_to_ws_valid), 70'(0));
    check("rst_late_ok_allowin", 70'(ms_allowin), 70'(1));
    tick();
    data_sram_data_ok = 1'b0;
    mid();
    check("rst_after_bus", ms_to_ws_bus, 70'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
